// File: rtl/alu_issue_if.sv
// alu_issue_if: registered ALU issue bundle handed from decode to execute.
interface alu_issue_if #(parameter int XLEN = 32);
    logic            valid;
    logic            ready;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [4:0]      rd;
    logic            wr_en;
    logic [31:0]     pc;
    logic            is_alu;
    logic            illegal;
    modport master (output valid, alu_op, alu_a, alu_b, rd, wr_en, pc, is_alu, illegal, input ready);
    modport slave  (input valid, alu_op, alu_a, alu_b, rd, wr_en, pc, is_alu, illegal, output ready);
endinterface

// File: rtl/alu_issue.sv
// alu_issue: RV32I decode/issue stage for ALU-class opcodes into a single-entry output register.
// Define ALU_ISSUE_ILLEGAL_EN to flag unsupported ALU encodings (SRA/SRAI, bad funct7) as illegal.
module alu_issue #(parameter int XLEN = 32) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [31:0]     in_pc,
    output logic [4:0]      rs1_idx,
    output logic [4:0]      rs2_idx,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    alu_issue_if.master     out
);
    localparam logic [3:0] ALU_NONE   = 4'd0;
    localparam logic [3:0] ALU_SHIFTL = 4'd1;
    localparam logic [3:0] ALU_SHIFTR = 4'd2;
    localparam logic [3:0] ALU_ADD    = 4'd4;
    localparam logic [3:0] ALU_SUB    = 4'd6;
    localparam logic [3:0] ALU_AND    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_XOR    = 4'd9;
    localparam logic [3:0] ALU_LT     = 4'd10;
    localparam logic [3:0] ALU_LTS    = 4'd11;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
`ifdef ALU_ISSUE_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif
    logic [6:0]      opc, f7;
    logic [2:0]      f3;
    logic [4:0]      rd;
    logic [31:0]     imm_i, imm_u;
    logic [3:0]      f3_op, d_op;
    logic [XLEN-1:0] d_a, d_b;
    logic            d_alu, d_bad, d_ill, shift, sub;
    assign opc      = in_instr[6:0];
    assign rd       = in_instr[11:7];
    assign f3       = in_instr[14:12];
    assign f7       = in_instr[31:25];
    assign rs1_idx  = in_instr[19:15];
    assign rs2_idx  = in_instr[24:20];
    assign imm_i    = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_u    = {in_instr[31:12], 12'b0};
    assign shift    = f3[1:0] == 2'b01;
    assign sub      = f7 == 7'h20 && f3 == 3'b000;
    assign d_ill    = ILL_EN && d_bad;
    assign in_ready = !out.valid || out.ready;
    always_comb begin
        case (f3)
            3'b000:  f3_op = ALU_ADD;
            3'b001:  f3_op = ALU_SHIFTL;
            3'b010:  f3_op = ALU_LTS;
            3'b011:  f3_op = ALU_LT;
            3'b100:  f3_op = ALU_XOR;
            3'b101:  f3_op = ALU_SHIFTR;
            3'b110:  f3_op = ALU_OR;
            default: f3_op = ALU_AND;
        endcase
    end
    // Shifts carry only the shift amount in b since the ALU shifts by the full operand.
    always_comb begin
        d_alu = 1'b1;
        d_bad = 1'b0;
        d_op  = ALU_ADD;
        d_a   = rs1_data;
        d_b   = rs2_data;
        if (opc == OPC_LUI) begin
            d_a = '0;
            d_b = imm_u;
        end else if (opc == OPC_AUIPC) begin
            d_a = in_pc;
            d_b = imm_u;
        end else if (opc == OPC_OPIMM) begin
            d_op  = f3_op;
            d_b   = shift ? {27'b0, in_instr[24:20]} : imm_i;
            d_bad = shift && f7 != 7'h00;
        end else if (opc == OPC_OP) begin
            d_op  = sub ? ALU_SUB : f3_op;
            d_b   = shift ? {27'b0, rs2_data[4:0]} : rs2_data;
            d_bad = f7 != 7'h00 && !sub;
        end else begin
            d_alu = 1'b0;
            d_op  = ALU_NONE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out.valid   <= 1'b0;
            out.alu_op  <= '0;
            out.alu_a   <= '0;
            out.alu_b   <= '0;
            out.rd      <= '0;
            out.wr_en   <= 1'b0;
            out.pc      <= '0;
            out.is_alu  <= 1'b0;
            out.illegal <= 1'b0;
        end else if (flush) begin
            out.valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out.valid   <= 1'b1;
            out.alu_op  <= d_op;
            out.alu_a   <= d_a;
            out.alu_b   <= d_b;
            out.rd      <= rd;
            out.wr_en   <= d_alu && !d_ill && rd != 5'd0;
            out.pc      <= in_pc;
            out.is_alu  <= d_alu;
            out.illegal <= d_ill;
        end else if (out.ready) begin
            out.valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed and randomized checks of alu_issue against a mnemonic-level reference model.
module tb_alu_issue;
    localparam logic [3:0] NONE = 4'd0, SHL = 4'd1, SHR = 4'd2, ADD = 4'd4, SUB = 4'd6;
    localparam logic [3:0] AND = 4'd7, OR = 4'd8, XOR = 4'd9, LT = 4'd10, LTS = 4'd11;
    localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, OPI = 7'h13, OPR = 7'h33;
`ifdef ALU_ISSUE_ILLEGAL_EN
    localparam bit ILL = 1'b1;
`else
    localparam bit ILL = 1'b0;
`endif
    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wr;
        logic [31:0] pc;
        logic        alu;
        logic        ill;
    } bundle_t;

    logic        clk = 1'b0, rst = 1'b0, in_valid = 1'b0, flush = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0, in_pc = '0;
    logic [4:0]  rs1_idx, rs2_idx;
    logic [31:0] rs1_data, rs2_data;
    logic [31:0] rf [32];
    int          total = 0, bad = 0;

    alu_issue_if #(.XLEN(32)) o ();
    alu_issue #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush), .out(o)
    );

    always #5 clk = ~clk;
    assign rs1_data = rf[rs1_idx];
    assign rs2_data = rf[rs2_idx];

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic bundle_t dut_b();
        return '{o.alu_op, o.alu_a, o.alu_b, o.rd, o.wr_en, o.pc, o.is_alu, o.illegal};
    endfunction

    // Reference: what each RV32I mnemonic should hand the ALU.
    function automatic bundle_t model(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] r1, input logic [31:0] r2);
        bundle_t     e;
        logic [6:0]  f7;
        logic [31:0] simm;
        f7   = ins[31:25];
        simm = 32'(signed'(ins[31:20]));
        e    = '{op: NONE, a: r1, b: r2, rd: ins[11:7], wr: 1'b0, pc: pc, alu: 1'b0, ill: 1'b0};
        case (ins[6:0])
            LUI:   begin e.alu = 1; e.op = ADD; e.a = 0;  e.b = {ins[31:12], 12'h000}; end
            AUIPC: begin e.alu = 1; e.op = ADD; e.a = pc; e.b = {ins[31:12], 12'h000}; end
            OPI: begin
                e.alu = 1;
                e.b   = simm;
                case (ins[14:12])
                    3'd0: e.op = ADD;
                    3'd1: begin e.op = SHL; e.b = 32'(ins[24:20]); e.ill = f7 != 0; end
                    3'd2: e.op = LTS;
                    3'd3: e.op = LT;
                    3'd4: e.op = XOR;
                    3'd5: begin e.op = SHR; e.b = 32'(ins[24:20]); e.ill = f7 != 0; end
                    3'd6: e.op = OR;
                    default: e.op = AND;
                endcase
            end
            OPR: begin
                e.alu = 1;
                e.ill = f7 != 0;
                case (ins[14:12])
                    3'd0: begin e.op = (f7 == 7'h20) ? SUB : ADD; e.ill = f7 != 0 && f7 != 7'h20; end
                    3'd1: begin e.op = SHL; e.b = r2 % 32; end
                    3'd2: e.op = LTS;
                    3'd3: e.op = LT;
                    3'd4: e.op = XOR;
                    3'd5: begin e.op = SHR; e.b = r2 % 32; end
                    3'd6: e.op = OR;
                    default: e.op = AND;
                endcase
            end
            default: ;
        endcase
        if (!ILL) e.ill = 1'b0;
        e.wr = e.alu && !e.ill && e.rd != 0;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 9);
        w[6:0] = k == 0 ? LUI : k == 1 ? AUIPC : k <= 4 ? OPI : k <= 7 ? OPR : k == 8 ? 7'h63 : 7'(w[6:0] | 7'h03);
        k = $urandom_range(0, 3);
        if (w[6:0] == OPI || w[6:0] == OPR)
            w[31:25] = k <= 1 ? 7'h00 : k == 2 ? 7'h20 : w[31:25];
        return w;
    endfunction

    // Called at a negedge: applies inputs, returns at the following negedge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic rdy, input logic fl);
        in_valid = v;
        in_instr = ins;
        in_pc    = pc;
        o.ready  = rdy;
        flush    = fl;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        o.ready = 1'b1;
        #1 rst = 1'b1;
        #1;
        total++;
        if (o.valid !== 1'b0 || dut_b() !== '0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset valid=%b bundle=%h in_ready=%b, want 0/0/1", o.valid, dut_b(), in_ready);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] ins [9];
        logic [31:0] pcs [9];
        bundle_t     exp [9];
        rf[1] = 32'd5;
        rf[2] = 32'h123;
        ins[0] = enc_i(12'hFFF, 5'd1, 3'd0, 5'd5, OPI);
        exp[0] = '{ADD, 32'd5, 32'hFFFFFFFF, 5'd5, 1'b1, 32'h100, 1'b1, 1'b0};
        ins[1] = enc_i(12'hFFF, 5'd0, 3'd3, 5'd2, OPI);
        exp[1] = '{LT, 32'd0, 32'hFFFFFFFF, 5'd2, 1'b1, 32'h104, 1'b1, 1'b0};
        ins[2] = enc_i({7'h00, 5'd31}, 5'd1, 3'd1, 5'd3, OPI);
        exp[2] = '{SHL, 32'd5, 32'd31, 5'd3, 1'b1, 32'h108, 1'b1, 1'b0};
        ins[3] = enc_r(7'h00, 5'd2, 5'd1, 3'd1, 5'd4, OPR);
        exp[3] = '{SHL, 32'd5, 32'd3, 5'd4, 1'b1, 32'h10C, 1'b1, 1'b0};
        ins[4] = {20'h12345, 5'd6, AUIPC};
        exp[4] = '{ADD, 32'h1000, 32'h12345000, 5'd6, 1'b1, 32'h1000, 1'b1, 1'b0};
        ins[5] = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0, OPR);
        exp[5] = '{ADD, 32'd5, 32'h123, 5'd0, 1'b0, 32'h1004, 1'b1, 1'b0};
        ins[6] = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd9, OPR);
        exp[6] = '{SUB, 32'd5, 32'h123, 5'd9, 1'b1, 32'h1008, 1'b1, 1'b0};
        ins[7] = {20'hABCDE, 5'd10, LUI};
        exp[7] = '{ADD, 32'd0, 32'hABCDE000, 5'd10, 1'b1, 32'h100C, 1'b1, 1'b0};
        ins[8] = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd5, 7'h63);
        exp[8] = '{NONE, 32'd5, 32'h123, 5'd5, 1'b0, 32'h1010, 1'b0, 1'b0};
        pcs = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1010};
        for (int i = 0; i < 9; i++) begin
            step(1'b1, ins[i], pcs[i], 1'b1, 1'b0);
            total++;
            if (o.valid !== 1'b1 || dut_b() !== exp[i]) begin
                bad++;
                $display("FAIL basic[%0d] valid=%b got=%h want=%h", i, o.valid, dut_b(), exp[i]);
            end
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_illegal();
        bundle_t e;
        rf[1] = 32'hF000_0000;
        rf[2] = 32'h0000_0024;
        step(1'b1, enc_i({7'h20, 5'd3}, 5'd1, 3'd5, 5'd7, OPI), 32'h200, 1'b1, 1'b0);
        e = '{SHR, 32'hF0000000, 32'd3, 5'd7, !ILL, 32'h200, 1'b1, ILL};
        total++;
        if (o.valid !== 1'b1 || dut_b() !== e) begin
            bad++;
            $display("FAIL srai got=%h want=%h", dut_b(), e);
        end
        step(1'b1, enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd8, OPR), 32'h204, 1'b1, 1'b0);
        e = '{SHR, 32'hF0000000, 32'd4, 5'd8, !ILL, 32'h204, 1'b1, ILL};
        total++;
        if (o.valid !== 1'b1 || dut_b() !== e) begin
            bad++;
            $display("FAIL sra got=%h want=%h", dut_b(), e);
        end
        step(1'b1, enc_r(7'h01, 5'd2, 5'd1, 3'd4, 5'd9, OPR), 32'h208, 1'b1, 1'b0);
        e = '{XOR, 32'hF0000000, 32'h24, 5'd9, !ILL, 32'h208, 1'b1, ILL};
        total++;
        if (o.valid !== 1'b1 || dut_b() !== e) begin
            bad++;
            $display("FAIL badf7 got=%h want=%h", dut_b(), e);
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_stall();
        logic [31:0] a, b;
        bundle_t     ea, eb;
        a  = enc_r(7'h00, 5'd4, 5'd3, 3'd6, 5'd11, OPR);
        b  = enc_i(12'h7FF, 5'd5, 3'd7, 5'd12, OPI);
        ea = model(a, 32'h300, rf[3], rf[4]);
        eb = model(b, 32'h304, rf[5], rf[0]);
        step(1'b1, a, 32'h300, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, b, 32'h304, 1'b0, 1'b0);
            total++;
            if (o.valid !== 1'b1 || dut_b() !== ea || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall[%0d] valid=%b got=%h want=%h in_ready=%b", i, o.valid, dut_b(), ea, in_ready);
            end
        end
        o.ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL release in_ready=%b want 1", in_ready);
        end
        step(1'b1, b, 32'h304, 1'b1, 1'b0);
        total++;
        if (o.valid !== 1'b1 || dut_b() !== eb) begin
            bad++;
            $display("FAIL after_stall got=%h want=%h", dut_b(), eb);
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
        total++;
        if (o.valid !== 1'b0) begin
            bad++;
            $display("FAIL no_dup valid=%b want 0", o.valid);
        end
    endtask

    task automatic test_flush();
        logic [31:0] a;
        a = enc_i(12'h010, 5'd1, 3'd0, 5'd1, OPI);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, a, 32'h400, 1'b1, 1'b0);
            step(1'b1, a, 32'h404, i == 0, 1'b1);
            total++;
            if (o.valid !== 1'b0) begin
                bad++;
                $display("FAIL flush[%0d] valid=%b want 0", i, o.valid);
            end
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_rst_mid();
        step(1'b1, {20'h55555, 5'd13, LUI}, 32'h500, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        total++;
        if (o.valid !== 1'b0 || dut_b() !== '0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid valid=%b bundle=%h in_ready=%b, want 0/0/1", o.valid, dut_b(), in_ready);
        end
        @(posedge clk);
        in_valid = 1'b0;
        @(negedge clk) rst = 1'b0;
        #1;
        total++;
        if (o.valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_drop valid=%b want 0", o.valid);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        bundle_t     q [$];
        bundle_t     e;
        logic [31:0] ins, pc;
        logic        v, rdy, fl, acc;
        for (int n = 0; n < 3000; n++) begin
            total++;
            if (o.valid !== (q.size() != 0)) begin
                bad++;
                $display("FAIL rnd_valid n=%0d got=%b want=%b", n, o.valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                total++;
                if (dut_b() !== q[0]) begin
                    bad++;
                    $display("FAIL rnd_data n=%0d got=%h want=%h", n, dut_b(), q[0]);
                end
            end
            if ($urandom_range(0, 3) == 0) rf[$urandom_range(1, 31)] = $urandom;
            ins = rand_instr();
            pc  = $urandom & 32'hFFFF_FFFC;
            v   = $urandom_range(0, 3) != 0;
            rdy = $urandom_range(0, 3) != 0;
            fl  = $urandom_range(0, 19) == 0;
            in_valid = v;
            in_instr = ins;
            in_pc    = pc;
            o.ready  = rdy;
            flush    = fl;
            #1;
            total++;
            if (in_ready !== (q.size() == 0 || rdy)) begin
                bad++;
                $display("FAIL rnd_in_ready n=%0d got=%b want=%b", n, in_ready, q.size() == 0 || rdy);
            end
            e   = model(ins, pc, rf[ins[19:15]], rf[ins[24:20]]);
            acc = v && (q.size() == 0 || rdy);
            @(posedge clk);
            if (fl) q.delete();
            else begin
                if (q.size() != 0 && rdy) void'(q.pop_front());
                if (acc) q.push_back(e);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;
        test_reset();
        test_basic();
        test_illegal();
        test_stall();
        test_flush();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end
endmodule
